// File: rtl/bist_sig_engine_pkg.sv
// bist_pkg: FSM states and the shared LFSR/MISR step function.
package bist_pkg;
  typedef enum logic [1:0] {IDLE, RESET_CUT, APPLY, DONE} state_t;
  localparam int MAXW = 64;
  function automatic logic [MAXW-1:0] sig_step(input logic [MAXW-1:0] s, poly, d, input int w);
    logic [MAXW-1:0] m, t;
    m = (w >= MAXW) ? '1 : ~('1 << w);
    t = s >> (w - 1);
    return ((s << 1) ^ (t[0] ? poly : '0) ^ d) & m;
  endfunction
endpackage

// File: rtl/bist_sig_engine_if.sv
// bist_sig_engine_if: control, status and CUT-side signals of the BIST engine.
interface bist_sig_engine_if #(parameter int IN_WIDTH = 14, OUT_WIDTH = 14, CNT_W = 8);
  logic start, abort, mode;
  logic [IN_WIDTH-1:0] ext_pat, cut_in;
  logic [OUT_WIDTH-1:0] golden_sig, cut_out, signature;
  logic cut_reset, busy, done, pass;
  logic [CNT_W-1:0] pat_idx;
  modport master (output start, abort, mode, ext_pat, golden_sig, cut_out,
                  input cut_in, cut_reset, busy, done, pass, signature, pat_idx);
  modport slave (input start, abort, mode, ext_pat, golden_sig, cut_out,
                 output cut_in, cut_reset, busy, done, pass, signature, pat_idx);
endinterface

// File: rtl/bist_sig_engine_sig_reg.sv
// sig_reg: loadable LFSR/MISR register; d=0 gives a pattern generator.
module sig_reg import bist_pkg::*; #(
  parameter int W = 8,
  parameter logic [W-1:0] POLY = '0,
  parameter logic [W-1:0] SEED = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (reset || load) q <= SEED;
    else if (en) q <= W'(sig_step(MAXW'(q), MAXW'(POLY), MAXW'(d), W));
endmodule

// File: rtl/bist_sig_engine.sv
// bist_sig_engine: TPG/external patterns into a CUT, MISR compaction, golden compare.
module bist_sig_engine import bist_pkg::*; #(
  parameter int IN_WIDTH = 14,
  parameter int OUT_WIDTH = 14,
  parameter logic [63:0] TPG_POLY = 64'h2B,
  parameter logic [63:0] TPG_SEED = 64'd1,
  parameter logic [63:0] MISR_POLY = 64'd277,
  parameter logic [63:0] MISR_SEED = 64'd0,
  parameter int NUM_PATTERNS = 225,
  parameter int CNT_W = $clog2(NUM_PATTERNS + 1)
) (
  input logic clk,
  input logic reset,
  bist_sig_engine_if.slave bus
);
  if (TPG_SEED[IN_WIDTH-1:0] == '0) begin : g_bad_seed
    $error("bist_sig_engine: TPG_SEED must be nonzero");
  end
  if (NUM_PATTERNS < 1) begin : g_bad_count
    $error("bist_sig_engine: NUM_PATTERNS must be at least 1");
  end
  state_t state, nxt;
  logic mode_q, go, last;
  logic [IN_WIDTH-1:0] cut_in_q, tpg_q;
  logic [OUT_WIDTH-1:0] misr_q;
  logic [CNT_W-1:0] pat_idx_q;
  assign go = bus.start && !bus.abort && (state == IDLE || state == DONE);
  assign last = state == APPLY && pat_idx_q == CNT_W'(NUM_PATTERNS - 1);
  always_comb
    nxt = bus.abort ? IDLE :
          go ? RESET_CUT :
          state == RESET_CUT ? APPLY :
          last ? DONE : state;
  // The TPG runs one step ahead of cut_in: it advances in RESET_CUT while the seed is on the CUT.
  sig_reg #(.W(IN_WIDTH), .POLY(TPG_POLY[IN_WIDTH-1:0]), .SEED(TPG_SEED[IN_WIDTH-1:0])) u_tpg (
    .clk, .reset, .load(go), .en(state == RESET_CUT || state == APPLY), .d('0), .q(tpg_q)
  );
  sig_reg #(.W(OUT_WIDTH), .POLY(MISR_POLY[OUT_WIDTH-1:0]), .SEED(MISR_SEED[OUT_WIDTH-1:0])) u_misr (
    .clk, .reset, .load(go), .en(state == APPLY), .d(bus.cut_out), .q(misr_q)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      mode_q <= 1'b0;
      cut_in_q <= '0;
      pat_idx_q <= '0;
    end else begin
      state <= nxt;
      if (bus.abort) begin
        cut_in_q <= '0;
        pat_idx_q <= '0;
      end else if (go) begin
        mode_q <= bus.mode;
        cut_in_q <= bus.mode ? bus.ext_pat : TPG_SEED[IN_WIDTH-1:0];
        pat_idx_q <= '0;
      end else if (state == APPLY) begin
        cut_in_q <= mode_q ? bus.ext_pat : tpg_q;
        pat_idx_q <= pat_idx_q + 1'b1;
      end
    end
  // The MISR is frozen outside APPLY, so the DONE view of it is stable.
  assign bus.cut_in = cut_in_q;
  assign bus.pat_idx = pat_idx_q;
  assign bus.cut_reset = state == RESET_CUT;
  assign bus.busy = state == RESET_CUT || state == APPLY;
  assign bus.done = state == DONE;
  assign bus.signature = state == DONE ? misr_q : '0;
  assign bus.pass = state == DONE && misr_q == bus.golden_sig;
endmodule

// File: tb/tb_bist_sig_engine.sv
// tb_bist_sig_engine: random/directed runs checked against an arithmetic reference model.
module tb_bist_sig_engine;
  localparam int IW = 14, OW = 14, N = 225, CW = $clog2(N + 1);
  localparam int TPOLY = 'h2B, TSEED = 1, MPOLY = 277, MSEED = 0;
  localparam logic [3:0] EXP4 [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                                      4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};
  logic clk = 1'b0, reset = 1'b1, fault = 1'b0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  bist_sig_engine_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_W(CW)) b ();
  bist_sig_engine_if #(.IN_WIDTH(4), .OUT_WIDTH(4), .CNT_W(5)) b4 ();

  function automatic int cut_fn(int x);
    return ((x * 37) ^ (x >> 3) ^ 'h1A5) & ((1 << OW) - 1);
  endfunction
  function automatic int step(int s, int d, int poly, int w);
    int mask = (1 << w) - 1;
    return ((s * 2) & mask) ^ (((s >> (w - 1)) & 1) != 0 ? (poly & mask) : 0) ^ (d & mask);
  endfunction

  assign b.cut_out = OW'(cut_fn(int'(b.cut_in))) | (fault ? OW'(1) : OW'(0));
  assign b4.cut_out = 4'h1;

  bist_sig_engine #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .TPG_POLY(TPOLY), .TPG_SEED(TSEED),
                    .MISR_POLY(MPOLY), .MISR_SEED(MSEED), .NUM_PATTERNS(N)) u_dut (
    .clk(clk), .reset(reset), .bus(b));
  bist_sig_engine #(.IN_WIDTH(4), .OUT_WIDTH(4), .TPG_POLY(3), .TPG_SEED(1),
                    .MISR_POLY(3), .MISR_SEED(0), .NUM_PATTERNS(16)) u_dut4 (
    .clk(clk), .reset(reset), .bus(b4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_cut_in"}, 64'(b.cut_in), 0);
    chk({tag, "_cut_reset"}, 64'(b.cut_reset), 0);
    chk({tag, "_busy"}, 64'(b.busy), 0);
    chk({tag, "_done"}, 64'(b.done), 0);
    chk({tag, "_pass"}, 64'(b.pass), 0);
    chk({tag, "_signature"}, 64'(b.signature), 0);
    chk({tag, "_pat_idx"}, 64'(b.pat_idx), 0);
  endtask

  // One full run from IDLE or DONE; cut_in, pat_idx, timing and signature checked each cycle.
  task automatic run(input string tag, input bit m, input bit poke, input bit use_gold,
                     input int gold, output int sig);
    int pats[N];
    int p = TSEED, poke_at = $urandom_range(1, N - 2), g;
    for (int k = 0; k < N; k++) begin
      pats[k] = m ? int'($urandom_range(0, (1 << IW) - 1)) : p;
      p = step(p, 0, TPOLY, IW);
    end
    sig = MSEED;
    for (int k = 0; k < N; k++) sig = step(sig, cut_fn(pats[k]) | int'(fault), MPOLY, OW);
    g = use_gold ? gold : sig;
    b.golden_sig = OW'(g);
    b.mode = m;
    b.ext_pat = IW'(pats[0]);
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
    b.mode = ~m;
    chk({tag, "_rc_cut_reset"}, 64'(b.cut_reset), 1);
    chk({tag, "_rc_busy"}, 64'(b.busy), 1);
    chk({tag, "_rc_cut_in"}, 64'(b.cut_in), 64'(pats[0]));
    tick();
    for (int j = 0; j < N; j++) begin
      b.ext_pat = (j + 1 < N) ? IW'(pats[(j + 1) % N]) : IW'($urandom);
      b.start = poke && j == poke_at;
      chk({tag, "_cut_in"}, 64'(b.cut_in), 64'(pats[j]));
      chk({tag, "_pat_idx"}, 64'(b.pat_idx), 64'(j));
      chk({tag, "_busy"}, 64'(b.busy), 1);
      chk({tag, "_cut_reset"}, 64'(b.cut_reset), 0);
      chk({tag, "_done_early"}, 64'(b.done), 0);
      tick();
    end
    b.start = 1'b0;
    chk({tag, "_done"}, 64'(b.done), 1);
    chk({tag, "_busy_done"}, 64'(b.busy), 0);
    chk({tag, "_signature"}, 64'(b.signature), 64'(sig));
    chk({tag, "_pass"}, 64'(b.pass), 64'(g == sig));
    chk({tag, "_pat_idx_end"}, 64'(b.pat_idx), 64'(N));
  endtask

  initial begin
    int good, s, tmp;
    b.start = 0; b.abort = 0; b.mode = 0; b.ext_pat = '0; b.golden_sig = '0;
    b4.start = 0; b4.abort = 0; b4.mode = 0; b4.ext_pat = '0; b4.golden_sig = '0;
    tick();
    tick();
    chk_idle("reset");
    reset = 1'b0;
    tick();
    chk_idle("idle");
    run("tpg", 1'b0, 1'b1, 1'b0, 0, good);
    run("ext_bad", 1'b1, 1'b0, 1'b1, good ^ 'h2A5, tmp);
    run("ext_good", 1'b1, 1'b1, 1'b0, 0, tmp);
    b.start = 1'b1;
    b.abort = 1'b1;
    tick();
    b.start = 1'b0;
    b.abort = 1'b0;
    chk("abort_over_start_busy", 64'(b.busy), 0);
    chk("abort_over_start_done", 64'(b.done), 0);
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_pat_idx_before", 64'(b.pat_idx), 2);
    b.abort = 1'b1;
    tick();
    b.abort = 1'b0;
    chk_idle("abort");
    run("after_abort", 1'b0, 1'b0, 1'b0, 0, s);
    chk("after_abort_same_sig", 64'(b.signature), 64'(good));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("reset_in_done");
    fault = 1'b1;
    run("stuck_at", 1'b0, 1'b0, 1'b1, good, s);
    chk("stuck_at_differs", 64'(b.signature != OW'(good)), 1);
    chk("stuck_at_fails", 64'(b.pass), 0);
    fault = 1'b0;
    s = 0;
    for (int k = 0; k < 16; k++) s = step(s, 1, 3, 4);
    b4.golden_sig = 4'(s);
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    tick();
    for (int j = 0; j < 16; j++) begin
      chk("tpg4_cut_in", 64'(b4.cut_in), 64'(EXP4[j]));
      tick();
    end
    chk("tpg4_done", 64'(b4.done), 1);
    chk("tpg4_signature", 64'(b4.signature), 64'(s));
    chk("tpg4_pass", 64'(b4.pass), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bist_sig_engine.md
# bist_sig_engine

Self-contained built-in self-test engine that generalises the fault-dictionary MISR flow into synthesizable hardware. It drives a circuit-under-test (CUT) with either LFSR-generated or externally supplied patterns, compacts the CUT responses in a parametrised MISR, and compares the final signature against a run-time golden value. It sits between the CUT wrapper and the test-access/status logic.

## Interface

Parameters:
- IN_WIDTH, 14, pattern width driven to CUT
- OUT_WIDTH, 14, CUT response width and MISR width
- TPG_POLY, 'h2B, TPG feedback mask (low IN_WIDTH bits used)
- TPG_SEED, 1, TPG initial state; must be nonzero (elaboration-time check)
- MISR_POLY, 277, MISR feedback mask (low OUT_WIDTH bits used)
- MISR_SEED, 0, MISR initial state
- NUM_PATTERNS, 225, patterns per run, ≥1
- CNT_W, $clog2(NUM_PATTERNS+1), pattern counter width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a run; sampled in IDLE or DONE only
- abort  in  1  terminate current run, return to IDLE
- mode  in  1  0 = internal TPG, 1 = external patterns; sampled with start
- ext_pat  in  IN_WIDTH  external pattern, used each APPLY cycle when mode=1
- golden_sig  in  OUT_WIDTH  expected signature, sampled in DONE entry cycle
- cut_in  out  IN_WIDTH  pattern to CUT (registered)
- cut_reset  out  1  CUT reset pulse
- cut_out  in  OUT_WIDTH  CUT response
- busy  out  1  high in RESET_CUT and APPLY
- done  out  1  high in DONE
- pass  out  1  signature == golden_sig; valid while done
- signature  out  OUT_WIDTH  final MISR value; valid while done
- pat_idx  out  CNT_W  index of pattern currently applied

## Operation

- Step function (shared by TPG and MISR), width W: next = {s[W-2:0],1'b0} ^ (s[W-1] ? POLY[W-1:0] : 0) ^ d. TPG uses d=0; MISR uses d=cut_out.
- FSM: IDLE → RESET_CUT → APPLY → DONE.
- IDLE: outputs idle; start → RESET_CUT, latch mode, TPG←TPG_SEED, MISR←MISR_SEED, pat_idx←0.
- RESET_CUT: exactly one cycle, cut_reset=1, cut_in = first pattern (TPG_SEED or ext_pat); → APPLY.
- APPLY: each cycle MISR←step(MISR, cut_out), pat_idx+1, cut_in←next pattern (TPG step or ext_pat). After NUM_PATTERNS captures → DONE.
- DONE: signature←MISR, pass←(MISR==golden_sig); held until start (restart, → RESET_CUT) or abort/reset (→ IDLE).
- abort in any non-IDLE state → IDLE next cycle; done/pass not asserted; has priority over start.
- start while busy ignored. mode/ext_pat changes mid-run: mode ignored, ext_pat consumed as presented.

## Timing

- Reset values: cut_in=0, cut_reset=0, busy=0, done=0, pass=0, signature=0, pat_idx=0, FSM=IDLE.
- start sampled at edge 0 → cut_reset high cycle 1 → APPLY cycles 2..NUM_PATTERNS+1 → done high from cycle NUM_PATTERNS+2.
- Pattern k on cut_in during APPLY cycle k; its response captured at the end of that cycle (CUT combinational path ≤ one cycle).
- TPG wraps freely at its period; pat_idx never exceeds NUM_PATTERNS.
- reset mid-run: synchronous return to reset values next edge, no partial signature exposed.

## Structure

- Package bist_pkg: state enum (IDLE, RESET_CUT, APPLY, DONE), parametrised sig_step function.
- Sub-module sig_reg (W, POLY, SEED; ports clk, reset, load, en, d, q), instantiated twice: TPG (d tied 0) and MISR.
- Top: FSM, counter, compare, output registers.

## Test plan

- W=4 MISR, MISR_POLY=4'h3, MISR_SEED=0, NUM_PATTERNS=3, cut_out=4'h1 constant → signature 4'h7; golden_sig 4'h7 → pass=1; golden_sig 4'h6 → pass=0.
- IN_WIDTH=4, TPG_POLY=4'h3, TPG_SEED=1, NUM_PATTERNS=16, mode=0 → cut_in sequence 1,2,4,8,3,6,C,B,… 15 distinct nonzero values, 16th equals 1.
- mode=1, NUM_PATTERNS=4, ext_pat 5,A,F,0 → cut_in echoes same order; done exactly 6 cycles after start.
- abort asserted in APPLY cycle 3 → IDLE next cycle, done=0, busy=0; new start yields signature identical to uninterrupted run.
- reset asserted in DONE → all outputs at reset values next cycle; start during busy has no effect on timing or signature.
- Injected single-bit stuck-at on cut_out[0] (forced 1) with default parameters → signature differs from fault-free run, pass=0.
